// File: rtl/divu_pkg.sv
// Shared definitions for the sequential unsigned divider: default width,
// FSM state encodings and the iteration-counter width helper.
package divu_pkg;

  localparam int DIVU_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter must hold WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/divu_step.sv
// One combinational iteration of restoring division: shift the next dividend
// bit into the partial remainder and subtract the divisor if it fits.
module divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem, dvd_msb};
  assign trial   = shifted - {1'b0, divisor};

  // A set carry-out bit means the shifted remainder already exceeds any divisor,
  // so the subtraction always fits even if the trial sign looks negative.
  assign q_bit    = shifted[WIDTH] | ~trial[WIDTH];
  assign next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/divu.sv
// Sequential unsigned divider (restoring, one quotient bit per clock) with a
// doDiv/div_done handshake. Optional div_zero output under DIVU_DIVZERO_FLAG_EN.
module divu
  import divu_pkg::*;
#(
  parameter int WIDTH = DIVU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             doDiv,
  output logic [WIDTH-1:0] Quot,
  output logic [WIDTH-1:0] Rem,
  output logic             busy,
  output logic             div_done
`ifdef DIVU_DIVZERO_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [CW-1:0]    count_reg;
  logic             load;
  logic             step;
  logic             finish;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  divu_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .dvd_msb  (dvd_reg[WIDTH-1]),
    .divisor  (divisor_reg),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (doDiv) begin
          load       = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (count_reg == '0) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        finish = 1'b1;
        if (doDiv) begin
          load       = 1'b1;
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Quotient bits replace dividend bits as they shift out of the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_reg     <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
      count_reg   <= '0;
      Quot        <= '0;
      Rem         <= '0;
      div_done    <= 1'b0;
`ifdef DIVU_DIVZERO_FLAG_EN
      div_zero    <= 1'b0;
`endif
    end else begin
      div_done <= finish;
      if (finish) begin
        Quot <= dvd_reg;
        Rem  <= rem_reg;
`ifdef DIVU_DIVZERO_FLAG_EN
        div_zero <= (divisor_reg == '0);
`endif
      end
      if (load) begin
        dvd_reg     <= a;
        divisor_reg <= b;
        rem_reg     <= '0;
        count_reg   <= CW'(WIDTH - 1);
      end else if (step) begin
        dvd_reg <= {dvd_reg[WIDTH-2:0], step_q};
        rem_reg <= step_rem;
        if (count_reg != '0) begin
          count_reg <= count_reg - 1'b1;
        end
      end
    end
  end

  assign busy = (state_reg == S_RUN);

endmodule

// File: tb/tb_divu.sv
// Directed testbench for divu (WIDTH=32) with hand-computed quotients/remainders.
module tb_divu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         doDiv;
  logic [W-1:0] Quot;
  logic [W-1:0] Rem;
  logic         busy;
  logic         div_done;
`ifdef DIVU_DIVZERO_FLAG_EN
  logic         div_zero;
`endif

  int n_checks = 0;
  int n_errors = 0;

  divu #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .doDiv    (doDiv),
    .Quot     (Quot),
    .Rem      (Rem),
    .busy     (busy),
    .div_done (div_done)
`ifdef DIVU_DIVZERO_FLAG_EN
    ,
    .div_zero (div_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Start one division, then follow it to div_done within a bounded window.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    int edges;
    int busy_cycles;
    bit seen;
    @(negedge clk);
    a = av; b = bv; doDiv = 1'b1;
    @(posedge clk);
    #1;
    doDiv = 1'b0;
    busy_cycles = busy ? 1 : 0;
    edges = 0;
    seen = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (div_done) seen = 1'b1;
      else if (busy) busy_cycles++;
    end
    check({tag, "_latency"}, edges, 33);
    check({tag, "_busy_cycles"}, busy_cycles, 32);
    check({tag, "_quot"}, Quot, eq);
    check({tag, "_rem"}, Rem, er);
    check({tag, "_busy_after"}, busy, 1'b0);
`ifdef DIVU_DIVZERO_FLAG_EN
    check({tag, "_div_zero"}, div_zero, ez);
`else
    if (ez) begin end
`endif
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, div_done, 1'b0);
    $display("op %s: a=%0h b=%0h -> Quot=%0h Rem=%0h after %0d edges", tag, av, bv, Quot, Rem, edges);
  endtask

  initial begin
    int bad;
    int edges;
    int first;
    int done_cnt;

    reset = 1'b1; doDiv = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_quot", Quot, 0);
    check("reset_rem", Rem, 0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", div_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (Quot != 0 || Rem != 0 || busy || div_done) bad++;
    end
    check("idle_quiet", bad, 0);
    $display("reset and idle sequence complete");

    run_op("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_op("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op("d3_5", 32'd3, 32'd5, 32'd0, 32'd3, 1'b0);
    run_op("dmsb_max", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_op("d5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run_op("d8_2", 32'd8, 32'd2, 32'd4, 32'd0, 1'b0);

    // Start request during RUN is ignored; held through DONE it starts a second op.
    @(negedge clk);
    a = 32'd100; b = 32'd7; doDiv = 1'b1;
    @(posedge clk);
    #1;
    doDiv = 1'b0;
    edges = 0;
    repeat (10) begin
      @(posedge clk);
      edges++;
    end
    #1;
    a = 32'd9; b = 32'd3; doDiv = 1'b1;
    first = 0;
    while (first == 0 && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (div_done) first = edges;
    end
    doDiv = 1'b0;
    check("busy_start_latency", first, 33);
    check("busy_start_quot", Quot, 14);
    check("busy_start_rem", Rem, 2);
    check("restart_in_done_busy", busy, 1'b1);
    $display("op overlap_first: a=64 b=7 -> Quot=%0h Rem=%0h", Quot, Rem);
    edges = 0;
    first = 0;
    while (first == 0 && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (div_done) first = edges;
    end
    check("restart_latency", first, 33);
    check("restart_quot", Quot, 3);
    check("restart_rem", Rem, 0);
    $display("op overlap_second: a=9 b=3 -> Quot=%0h Rem=%0h", Quot, Rem);

    // Reset in the middle of RUN abandons the operation.
    @(negedge clk);
    a = 32'd100; b = 32'd7; doDiv = 1'b1;
    @(posedge clk);
    #1;
    doDiv = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset_quot", Quot, 0);
    check("midreset_rem", Rem, 0);
    check("midreset_busy", busy, 1'b0);
    check("midreset_done", div_done, 1'b0);
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (div_done) done_cnt++;
    end
    check("midreset_no_done", done_cnt, 0);
    $display("op midreset: a=64 b=7 abandoned, div_done count=%0d", done_cnt);
    run_op("d50_6", 32'd50, 32'd6, 32'd8, 32'd2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
